// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants, framebuffer widths and the 3->8 bit colour
// expansion shared by the vga_plot_sink files.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam int ADDR_W   = 15;
    localparam int COLOR_W  = 9;

    // Replicating the MSBs makes 3'b111 map to full scale 8'hFF.
    function automatic logic [7:0] expand3(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

endpackage

// File: rtl/vga_plot_sink_if.sv
// Pixel write port of vga_plot_sink: the plotting client is the master,
// the display sink is the slave.
interface vga_plot_sink_if;
    import vga_pkg::*;

    // plot acts as valid and ~busy as ready: a write transfers on a CLOCK_50
    // rising edge where plot=1 and busy=0; x, y and color only matter then.
    logic               plot;
    logic [7:0]         x;
    logic [6:0]         y;
    logic [COLOR_W-1:0] color;
    logic               busy;

    modport master (output plot, x, y, color, input busy);
    modport slave  (input plot, x, y, color, output busy);

endinterface

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer: one write port, one registered read port.
// A same-edge read of the address being written returns the old word.
module fb_ram
    import vga_pkg::*;
#(
    parameter int DEPTH = 19200
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [ADDR_W-1:0]  wr_addr_i,
    input  logic [COLOR_W-1:0] wr_data_i,
    input  logic               re_i,
    input  logic [ADDR_W-1:0]  rd_addr_i,
    output logic [COLOR_W-1:0] rd_data_o
);

    logic [COLOR_W-1:0] mem_q [DEPTH];
    logic [COLOR_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (re_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/vga_plot_sink.sv
// 640x480 VGA scan-out of a FB_W x FB_H, 9-bit colour framebuffer with a pixel
// write port. Define FB_CLEAR_EN to zero the framebuffer after every reset.
module vga_plot_sink
    import vga_pkg::*;
#(
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int SCALE_LOG2 = 2
) (
    input  logic           CLOCK_50,
    input  logic           reset,
    vga_plot_sink_if.slave wr,
    output logic [7:0]     VGA_R,
    output logic [7:0]     VGA_G,
    output logic [7:0]     VGA_B,
    output logic           VGA_HS,
    output logic           VGA_VS,
    output logic           VGA_BLANK_N,
    output logic           VGA_SYNC_N,
    output logic           VGA_CLK,
    output logic           frame_start
);

    localparam int FB_DEPTH = FB_W * FB_H;

    logic               pix_en_q;
    logic [9:0]         hcount_q, hcount_d;
    logic [9:0]         vcount_q, vcount_d;
    logic               hs_act_q, vs_act_q, active_q;
    logic               frame_start_q;
    logic               in_active, in_hs, in_vs;
    logic [ADDR_W-1:0]  rd_addr, user_addr, wr_addr;
    logic [COLOR_W-1:0] wr_data, rd_data;
    logic               we, wr_ok, busy;

    assign in_active = (hcount_q < 10'(H_ACTIVE)) && (vcount_q < 10'(V_ACTIVE));
    assign in_hs     = (hcount_q >= 10'(HS_START)) && (hcount_q < 10'(HS_END));
    assign in_vs     = (vcount_q >= 10'(VS_START)) && (vcount_q < 10'(VS_END));

    always_comb begin
        hcount_d = hcount_q + 10'd1;
        vcount_d = vcount_q;
        if (hcount_q == 10'(H_TOTAL - 1)) begin
            hcount_d = '0;
            vcount_d = (vcount_q == 10'(V_TOTAL - 1)) ? '0 : vcount_q + 10'd1;
        end
    end

    // Sync/blank flags are stored active-high so reset clears the whole stage
    // to zero; they are registered with the read so they stay pixel-aligned.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pix_en_q      <= 1'b0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            hs_act_q      <= 1'b0;
            vs_act_q      <= 1'b0;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pix_en_q      <= ~pix_en_q;
            frame_start_q <= pix_en_q && (hcount_q == '0) && (vcount_q == '0);
            if (pix_en_q) begin
                hcount_q <= hcount_d;
                vcount_q <= vcount_d;
                hs_act_q <= in_hs;
                vs_act_q <= in_vs;
                active_q <= in_active;
            end
        end
    end

    assign rd_addr   = ADDR_W'((32'(vcount_q) >> SCALE_LOG2) * FB_W
                             + (32'(hcount_q) >> SCALE_LOG2));
    assign user_addr = ADDR_W'(32'(wr.y) * FB_W + 32'(wr.x));
    assign wr_ok     = wr.plot && !busy
                    && ({24'd0, wr.x} < 32'(FB_W))
                    && ({25'd0, wr.y} < 32'(FB_H));

`ifdef FB_CLEAR_EN
    logic              busy_q;
    logic [ADDR_W-1:0] clr_addr_q;

    // The clear owns the write port until the last address has been zeroed.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            busy_q     <= 1'b1;
            clr_addr_q <= '0;
        end else if (busy_q) begin
            if (clr_addr_q == ADDR_W'(FB_DEPTH - 1)) begin
                busy_q <= 1'b0;
            end
            clr_addr_q <= clr_addr_q + ADDR_W'(1);
        end
    end

    assign busy    = busy_q;
    assign we      = busy_q | wr_ok;
    assign wr_addr = busy_q ? clr_addr_q : user_addr;
    assign wr_data = busy_q ? '0 : wr.color;
`else
    assign busy    = 1'b0;
    assign we      = wr_ok;
    assign wr_addr = user_addr;
    assign wr_data = wr.color;
`endif

    assign wr.busy = busy;

    fb_ram #(
        .DEPTH(FB_DEPTH)
    ) u_fb_ram (
        .clk      (CLOCK_50),
        .we_i     (we),
        .wr_addr_i(wr_addr),
        .wr_data_i(wr_data),
        .re_i     (pix_en_q & in_active),
        .rd_addr_i(rd_addr),
        .rd_data_o(rd_data)
    );

    assign VGA_HS      = ~hs_act_q;
    assign VGA_VS      = ~vs_act_q;
    assign VGA_BLANK_N = active_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = ~pix_en_q;
    assign frame_start = frame_start_q;
    assign VGA_R       = active_q ? expand3(rd_data[8:6]) : 8'd0;
    assign VGA_G       = active_q ? expand3(rd_data[5:3]) : 8'd0;
    assign VGA_B       = active_q ? expand3(rd_data[2:0]) : 8'd0;

endmodule

// File: doc/vga_plot_sink.md
VGA_PLOT_SINK -- requirements
Module: vga_plot_sink

Interface
REQ-001 Parameter FB_W, default 160, framebuffer width in pixels.
REQ-002 Parameter FB_H, default 120, framebuffer height in pixels.
REQ-003 Parameter SCALE_LOG2, default 2, each framebuffer pixel spans 4x4 screen pixels.
REQ-004 CLOCK_50  in  1  the block's only clock, 50 MHz; all state changes on its rising edge.
REQ-005 reset  in  1  reset input, asynchronous and active-high.
REQ-006 plot  in  1  write strobe; one write per cycle when high.
REQ-007 x  in  8  write column.
REQ-008 y  in  7  write row.
REQ-009 color  in  9  write colour, {R[2:0],G[2:0],B[2:0]}.
REQ-010 busy  out  1  high while writes are not accepted.
REQ-011 VGA_R, VGA_G, VGA_B  out  8 each  expanded pixel colour.
REQ-012 VGA_HS, VGA_VS  out  1  syncs, active-low.
REQ-013 VGA_BLANK_N  out  1  high only in the active region.
REQ-014 VGA_SYNC_N  out  1  constant 0.
REQ-015 VGA_CLK  out  1  25 MHz pixel clock, CLOCK_50 divided by 2.
REQ-016 frame_start  out  1  one-CLOCK_50 pulse when hcount=0 and vcount=0.

Function
REQ-017 The pixel enable shall toggle every CLOCK_50 cycle. VGA_CLK shall equal the inverted pixel enable, so outputs change on VGA_CLK falling edges.
REQ-018 hcount shall run 0..799 and vcount 0..524, advancing on the pixel enable; vcount shall increment when hcount wraps from 799 to 0, and wrap from 524 to 0.
REQ-019 Active region: hcount<640 and vcount<480. HS low for hcount 656..751; VS low for vcount 490..491.
REQ-020 Read address = (vcount>>SCALE_LOG2)*FB_W + (hcount>>SCALE_LOG2), width 15 bits; the framebuffer read shall be synchronous with 1 pixel-enable latency.
REQ-021 HS, VS and BLANK_N shall be delayed by the same 1 pixel-enable stage so they stay aligned with the pixel data.
REQ-022 Channel expansion shall be c[2:0] -> {c,c,c[2:1]}; outputs shall be 0 whenever BLANK_N is low.
REQ-023 A write shall be accepted when plot=1, busy=0, x<FB_W and y<FB_H, and shall be stored at address y*FB_W+x in the same cycle; out-of-range writes shall be silently dropped.
REQ-024 Writes shall be independent of scan-out timing. On a same-cycle read/write to one address, the read shall return the old data.
REQ-025 A write to a pixel becomes visible in the next frame scanned past that pixel.

Reset
REQ-026 Reset shall clear hcount, vcount, pixel enable, the pipeline stage and frame_start to 0.
REQ-027 During reset VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_R/G/B=0 and VGA_CLK=1.
REQ-028 Reset mid-frame shall restart scan at (0,0); framebuffer contents shall be retained unless REQ-030 applies.

Configuration
REQ-029 Macro FB_CLEAR_EN absent: busy shall be constant 0 and the framebuffer shall not be cleared by reset.
REQ-030 Macro FB_CLEAR_EN defined: after reset deasserts, a clear counter shall write 0 to addresses 0..FB_W*FB_H-1, one address per CLOCK_50 cycle. busy shall be 1 from reset until the cycle after the last address is written. plot shall be ignored while busy=1. A new reset restarts the clear from address 0.

Structure
REQ-031 Package vga_pkg shall hold the timing constants (H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33) and the colour-expansion function.
REQ-032 Sub-module fb_ram shall be a simple dual-port RAM (one write port, one synchronous read port) of FB_W*FB_H x 9 bits with no reset on its array.

Verification
REQ-033 Release reset, run 2 frames -> frame_start pulses exactly 840000 CLOCK_50 cycles apart; HS low for 192 cycles per line; VS low for 2 lines.
REQ-034 plot (x=5, y=3, color=9'b111_000_000) -> in the next frame, screen pixels hcount 20..23 and vcount 12..15 show R=8'hFF, G=0, B=0 with BLANK_N=1; neighbouring pixels are unchanged.
REQ-035 plot with x=160 or y=120 -> no framebuffer location changes; a prior write at (0,0) still reads back its value.
REQ-036 Assert reset for 3 cycles mid-line at hcount=300 -> HS=1, VS=1, BLANK_N=0 during reset; scan resumes at (0,0); previously written pixels are still displayed (FB_CLEAR_EN undefined).
REQ-037 FB_CLEAR_EN defined, framebuffer preloaded non-zero, reset -> busy=1 for 19200 cycles; a plot issued during busy is dropped; after busy falls, every displayed pixel is 0.
REQ-038 Write address A in the same cycle the scan reads A -> that frame shows the old colour and the next frame shows the new colour.
